// File: rtl/map_table.sv
// Rename map table: architectural register -> physical tag/valid/ready.
// Optional same-cycle CDB forwarding on the read ports: MAP_TABLE_CDB_FWD_EN.
package sys_defs_pkg;
  localparam int SYS_PHYS_REG_SZ = 64;
  localparam int TAG_W = $clog2(SYS_PHYS_REG_SZ);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             valid;
    logic             ready;
  } TAG;

  typedef enum logic [1:0] {
    READ  = 2'b00,
    WRITE = 2'b01
  } COMMAND;
endpackage

module map_table
  import sys_defs_pkg::*;
#(
  parameter int ARCH_REG_SZ = 32,
  parameter int PHYS_REG_SZ = SYS_PHYS_REG_SZ
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           CDB_enable,
  input  TAG                             CDB,
  input  COMMAND                         command,
  input  logic [$clog2(PHYS_REG_SZ)-1:0] reg_t,
  input  logic [$clog2(PHYS_REG_SZ)-1:0] reg_t1,
  input  logic [$clog2(PHYS_REG_SZ)-1:0] reg_t2,
  input  TAG                             t,
  input  TAG                             t1,
  input  TAG                             t2,
  output TAG                             t_out,
  output TAG                             t1_out,
  output TAG                             t2_out
);

  localparam int IW = $clog2(PHYS_REG_SZ);
  localparam int AW = (ARCH_REG_SZ > 1) ? $clog2(ARCH_REG_SZ) : 1;
  localparam logic [IW:0] ARCH_LIM = (IW+1)'(ARCH_REG_SZ);

  TAG map_q [ARCH_REG_SZ];
  TAG map_d [ARCH_REG_SZ];

  // Only the tag of a broadcast is meaningful here.
  logic unused_cdb;
  assign unused_cdb = CDB.valid ^ CDB.ready;

  function automatic logic in_rng(input logic [IW-1:0] idx);
    return ({1'b0, idx} < ARCH_LIM);
  endfunction

  // A freshly written tag that completes this cycle is stored ready.
  function automatic TAG wr_val(input TAG x);
    TAG y;
    y = x;
    if (CDB_enable && (x.tag == CDB.tag))
      y.ready = 1'b1;
    return y;
  endfunction

  function automatic TAG rd(input logic [IW-1:0] idx);
    TAG y;
    y = '0;
    if (in_rng(idx))
      y = map_q[idx[AW-1:0]];
    return y;
  endfunction

  function automatic logic cdb_hit(input TAG x);
    return CDB_enable && x.valid && (x.tag == CDB.tag);
  endfunction

  // Next table: CDB wakeup first, then writes t2, t1, t so t has priority.
  always_comb begin
    for (int i = 0; i < ARCH_REG_SZ; i++) begin
      map_d[i] = map_q[i];
      if (cdb_hit(map_q[i]))
        map_d[i].ready = 1'b1;
    end
    if (command == WRITE) begin
      if (t2.valid && in_rng(reg_t2))
        map_d[reg_t2[AW-1:0]] = wr_val(t2);
      if (t1.valid && in_rng(reg_t1))
        map_d[reg_t1[AW-1:0]] = wr_val(t1);
      if (t.valid && in_rng(reg_t))
        map_d[reg_t[AW-1:0]] = wr_val(t);
    end
  end

  // Table state; reset restores the identity mapping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ARCH_REG_SZ; i++) begin
        map_q[i] <= '{tag: TAG_W'(i), valid: 1'b1, ready: 1'b1};
      end
    end else begin
      for (int i = 0; i < ARCH_REG_SZ; i++) begin
        map_q[i] <= map_d[i];
      end
    end
  end

  // Zero-latency read ports showing pre-write contents.
  always_comb begin
    t_out  = rd(reg_t);
    t1_out = rd(reg_t1);
    t2_out = rd(reg_t2);
`ifdef MAP_TABLE_CDB_FWD_EN
    t_out.ready  = t_out.ready  | cdb_hit(t_out);
    t1_out.ready = t1_out.ready | cdb_hit(t1_out);
    t2_out.ready = t2_out.ready | cdb_hit(t2_out);
`endif
  end

endmodule

// File: tb/tb_map_table.sv
// Scoreboard bench for map_table.
// Expected read-port values are queued at drive time, popped at negedge.
module tb_map_table;
  import sys_defs_pkg::*;

  logic   clock = 1'b0;
  logic   reset = 1'b0;
  logic   cdb_en = 1'b0;
  TAG     cdb = '0;
  COMMAND cmd = READ;
  logic [5:0] r0 = '0;
  logic [5:0] r1 = '0;
  logic [5:0] r2 = '0;
  TAG     ta = '0;
  TAG     tb = '0;
  TAG     tc = '0;
  TAG     o0;
  TAG     o1;
  TAG     o2;

  typedef struct {
    string nm;
    TAG    e0;
    TAG    e1;
    TAG    e2;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

`ifdef MAP_TABLE_CDB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  map_table dut (
    .clock      (clock),
    .reset      (reset),
    .CDB_enable (cdb_en),
    .CDB        (cdb),
    .command    (cmd),
    .reg_t      (r0),
    .reg_t1     (r1),
    .reg_t2     (r2),
    .t          (ta),
    .t1         (tb),
    .t2         (tc),
    .t_out      (o0),
    .t1_out     (o1),
    .t2_out     (o2)
  );

  always #5 clock = ~clock;

  function automatic TAG tg(input int tag, input bit v, input bit r);
    TAG x;
    x.tag = 6'(tag);
    x.valid = v;
    x.ready = r;
    return x;
  endfunction

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({e.nm, ".t"},  32'(o0), 32'(e.e0));
      check({e.nm, ".t1"}, 32'(o1), 32'(e.e1));
      check({e.nm, ".t2"}, 32'(o2), 32'(e.e2));
    end
  endtask

  task automatic drive(input COMMAND c,
                       input int a0, input int a1, input int a2,
                       input TAG x0, input TAG x1, input TAG x2,
                       input bit ce, input int ct);
    cmd = c;
    r0 = 6'(a0);
    r1 = 6'(a1);
    r2 = 6'(a2);
    ta = x0;
    tb = x1;
    tc = x2;
    cdb_en = ce;
    cdb = tg(ct, 1'b1, 1'b0);
  endtask

  task automatic cyc(input string nm, input COMMAND c,
                     input int a0, input int a1, input int a2,
                     input TAG x0, input TAG x1, input TAG x2,
                     input bit ce, input int ct,
                     input TAG e0, input TAG e1, input TAG e2);
    drive(c, a0, a1, a2, x0, x1, x2, ce, ct);
    sb.push_back('{nm, e0, e1, e2});
    @(negedge clock);
    pop_cmp();
    @(posedge clock);
    #1;
  endtask

  task automatic rd3(input string nm, input int a0, input int a1,
                     input int a2, input TAG e0, input TAG e1, input TAG e2);
    cyc(nm, READ, a0, a1, a2, '0, '0, '0, 1'b0, 0, e0, e1, e2);
  endtask

  TAG z;
  TAG id0, id1, id2;

  initial begin
    z = '0;
    id0 = tg(0, 1, 1);
    id1 = tg(1, 1, 1);
    id2 = tg(2, 1, 1);

    rd3("rst_id", 0, 1, 2, id0, id1, id2);
    cyc("rst_wr", WRITE, 0, 1, 31, tg(20, 1, 0), tg(21, 1, 0),
        tg(22, 1, 0), 1'b1, 31, id0, id1, tg(31, 1, 1));
    rd3("rst_hold", 0, 1, 31, id0, id1, tg(31, 1, 1));

    reset = 1'b1;
    rd3("rel_id", 0, 1, 2, id0, id1, id2);

    cyc("w0", WRITE, 0, 1, 2, tg(3, 1, 0), tg(30, 0, 0), tg(30, 0, 0),
        1'b0, 0, id0, id1, id2);
    cyc("w1", WRITE, 0, 1, 2, tg(30, 0, 0), tg(4, 1, 0), tg(30, 0, 0),
        1'b0, 0, tg(3, 1, 0), id1, id2);
    cyc("w2", WRITE, 0, 1, 2, tg(30, 0, 0), tg(30, 0, 0), tg(5, 1, 0),
        1'b0, 0, tg(3, 1, 0), tg(4, 1, 0), id2);
    rd3("rd012", 0, 1, 2, tg(3, 1, 0), tg(4, 1, 0), tg(5, 1, 0));

    cyc("cdb4", READ, 0, 1, 2, '0, '0, '0, 1'b1, 4,
        tg(3, 1, 0), tg(4, 1, FWD), tg(5, 1, 0));
    rd3("cdb4_aft", 0, 1, 2, tg(3, 1, 0), tg(4, 1, 1), tg(5, 1, 0));
    cyc("cdb3_off", READ, 0, 1, 2, '0, '0, '0, 1'b0, 3,
        tg(3, 1, 0), tg(4, 1, 1), tg(5, 1, 0));
    rd3("cdb3_hold", 0, 1, 2, tg(3, 1, 0), tg(4, 1, 1), tg(5, 1, 0));

    cyc("prio_t", WRITE, 7, 7, 8, tg(9, 1, 0), tg(10, 1, 0),
        tg(30, 0, 0), 1'b0, 0, tg(7, 1, 1), tg(7, 1, 1), tg(8, 1, 1));
    rd3("prio_t_rd", 7, 7, 8, tg(9, 1, 0), tg(9, 1, 0), tg(8, 1, 1));
    cyc("inval", WRITE, 7, 7, 7, tg(11, 0, 0), tg(12, 0, 0),
        tg(13, 0, 0), 1'b0, 0, tg(9, 1, 0), tg(9, 1, 0), tg(9, 1, 0));
    rd3("inval_rd", 7, 6, 6, tg(9, 1, 0), tg(6, 1, 1), tg(6, 1, 1));

    cyc("prio_t1", WRITE, 6, 6, 6, tg(30, 0, 0), tg(13, 1, 0),
        tg(14, 1, 0), 1'b0, 0, tg(6, 1, 1), tg(6, 1, 1), tg(6, 1, 1));
    rd3("prio_t1_rd", 6, 6, 3, tg(13, 1, 0), tg(13, 1, 0), tg(3, 1, 1));

    cyc("bad_cmd", COMMAND'(2'b10), 3, 4, 9, tg(15, 1, 0),
        tg(16, 1, 0), tg(17, 1, 0), 1'b0, 0,
        tg(3, 1, 1), tg(4, 1, 1), tg(9, 1, 1));
    rd3("bad_cmd_rd", 3, 4, 9, tg(3, 1, 1), tg(4, 1, 1), tg(9, 1, 1));

    cyc("oor_wr", WRITE, 40, 32, 63, tg(16, 1, 0), tg(17, 1, 0),
        tg(18, 1, 0), 1'b0, 0, z, z, z);
    rd3("oor_rd", 40, 0, 31, z, tg(3, 1, 0), tg(31, 1, 1));

    cyc("wr_cdb", WRITE, 5, 1, 2, tg(12, 1, 0), tg(30, 0, 0),
        tg(30, 0, 0), 1'b1, 12, tg(5, 1, 1), tg(4, 1, 1), tg(5, 1, 0));
    rd3("wr_cdb_rd", 5, 1, 2, tg(12, 1, 1), tg(4, 1, 1), tg(5, 1, 0));

    cyc("dup_w", WRITE, 10, 11, 12, tg(20, 1, 0), tg(20, 1, 0),
        tg(30, 0, 0), 1'b0, 0,
        tg(10, 1, 1), tg(11, 1, 1), tg(12, 1, 1));
    cyc("dup_cdb", READ, 10, 11, 12, '0, '0, '0, 1'b1, 20,
        tg(20, 1, FWD), tg(20, 1, FWD), tg(12, 1, 1));
    rd3("dup_aft", 10, 11, 0, tg(20, 1, 1), tg(20, 1, 1), tg(3, 1, 0));

    drive(READ, 0, 1, 40, '0, '0, '0, 1'b0, 0);
    reset = 1'b0;
    sb.push_back('{"mid_rst", id0, id1, z});
    #1;
    pop_cmp();
    cyc("mid_rst_w", WRITE, 7, 10, 2, tg(25, 1, 0), tg(26, 1, 0),
        tg(27, 1, 0), 1'b1, 7, tg(7, 1, 1), tg(10, 1, 1), id2);
    reset = 1'b1;
    rd3("post_rst", 7, 10, 5, tg(7, 1, 1), tg(10, 1, 1), tg(5, 1, 1));

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
